// File: rtl/sprite_motion_ctrl_if.sv
// Draw-request bundle between the sprite motion controller and the VGA drawing stage.
// master: the controller; slave: whoever drives run/colour/done and consumes the request.
interface sprite_motion_ctrl_if;
  logic       iEnable;
  logic [2:0] iColour;
  logic       iDone;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oLoadX;
  logic       oBusy;

  modport master (
    input  iEnable, iColour, iDone,
    output oX, oY, oColour, oLoadX, oBusy
  );

  modport slave (
    output iEnable, iColour, iDone,
    input  oX, oY, oColour, oLoadX, oBusy
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Paces a bouncing 4x4 sprite: one draw request per step, wall reflection per axis.
// Optional macro SPRITE_COLOUR_CYCLE_EN: colour is internal and advances on every bounce.
module sprite_motion_ctrl #(
  parameter int unsigned X_MAX           = 156,
  parameter int unsigned Y_MAX           = 116,
  parameter int unsigned FRAME_DIV       = 833333,
  parameter int unsigned FRAMES_PER_STEP = 4
) (
  input  logic                 iClock,
  input  logic                 iResetn,
  sprite_motion_ctrl_if.master bus
);

  localparam int unsigned DivW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned FrmW = $clog2(FRAMES_PER_STEP + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitDone, StWaitTick, StMove} state_e;

  state_e            state_q;
  logic [DivW-1:0]   div_q;
  logic [FrmW-1:0]   frm_q;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic              dir_x_q, dir_y_q;
  logic [2:0]        col_q;
  logic              load_q, busy_q;

  logic              tick;
  logic [7:0]        x_mv;
  logic [6:0]        y_mv;
  logic              dir_x_mv, dir_y_mv, refl_x, refl_y;
  logic [2:0]        col_idle, col_move;

  assign tick = (div_q == DivW'(FRAME_DIV - 1));

  // Reflection keeps the sprite inside [0, MAX]: the step that hits a wall moves back one.
  always_comb begin
    x_mv     = x_q + 8'd1;
    dir_x_mv = dir_x_q;
    refl_x   = 1'b0;
    if (dir_x_q) begin
      if (x_q == 8'(X_MAX)) begin
        x_mv     = x_q - 8'd1;
        dir_x_mv = 1'b0;
        refl_x   = 1'b1;
      end
    end else if (x_q == 8'd0) begin
      dir_x_mv = 1'b1;
      refl_x   = 1'b1;
    end else begin
      x_mv = x_q - 8'd1;
    end

    y_mv     = y_q + 7'd1;
    dir_y_mv = dir_y_q;
    refl_y   = 1'b0;
    if (dir_y_q) begin
      if (y_q == 7'(Y_MAX)) begin
        y_mv     = y_q - 7'd1;
        dir_y_mv = 1'b0;
        refl_y   = 1'b1;
      end
    end else if (y_q == 7'd0) begin
      dir_y_mv = 1'b1;
      refl_y   = 1'b1;
    end else begin
      y_mv = y_q - 7'd1;
    end
  end

`ifdef SPRITE_COLOUR_CYCLE_EN
  localparam logic [2:0] ColRst = 3'd1;
  logic unused_colour;
  assign unused_colour = ^bus.iColour;

  always_comb begin
    col_idle = col_q;
    col_move = col_q;
    if (refl_x || refl_y) col_move = (col_q == 3'd7) ? 3'd1 : col_q + 3'd1;
  end
`else
  localparam logic [2:0] ColRst = 3'd0;
  logic unused_refl;
  assign unused_refl = refl_x ^ refl_y;

  always_comb begin
    col_idle = bus.iColour;
    col_move = bus.iColour;
  end
`endif

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state_q <= StIdle;
      div_q   <= '0;
      frm_q   <= '0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      col_q   <= ColRst;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          load_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.iEnable) begin
            state_q <= StIssue;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            col_q   <= col_idle;
          end
        end
        StIssue: begin
          load_q  <= 1'b0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (bus.iDone) begin
            state_q <= StWaitTick;
            frm_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        StWaitTick: begin
          if (!bus.iEnable) begin
            state_q <= StIdle;
          end else if (tick) begin
            if (frm_q == FrmW'(FRAMES_PER_STEP - 1)) state_q <= StMove;
            else                                     frm_q   <= frm_q + 1'b1;
          end
        end
        StMove: begin
          x_q     <= x_mv;
          y_q     <= y_mv;
          dir_x_q <= dir_x_mv;
          dir_y_q <= dir_y_mv;
          col_q   <= col_move;
          state_q <= StIssue;
          load_q  <= 1'b1;
          busy_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.oX      = x_q;
  assign bus.oY      = y_q;
  assign bus.oColour = col_q;
  assign bus.oLoadX  = load_q;
  assign bus.oBusy   = busy_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with a small 4x3 playfield and fast frame ticks.
module tb_sprite_motion_ctrl;
  localparam int unsigned FDIV = 4;
  localparam int unsigned FPS  = 2;
  localparam int unsigned XM   = 3;
  localparam int unsigned YM   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  sprite_motion_ctrl_if bus ();

  sprite_motion_ctrl #(
    .X_MAX          (XM),
    .Y_MAX          (YM),
    .FRAME_DIV      (FDIV),
    .FRAMES_PER_STEP(FPS)
  ) dut (
    .iClock (clk),
    .iResetn(rst_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int bound_viol = 0;

  // Hand-traced bounce path from (0,0), both directions +1, X_MAX=3, Y_MAX=2.
  // Steps 7 and 13 reflect both axes in one move (from (0,2) and (0,0)).
  int exp_x  [14] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1};
  int exp_y  [14] = '{0, 1, 2, 1, 0, 1, 2, 1, 0, 1, 2, 1, 0, 1};
  int cyc_col[14] = '{1, 1, 1, 2, 3, 4, 4, 5, 5, 6, 7, 1, 1, 2};

`ifdef SPRITE_COLOUR_CYCLE_EN
  localparam int RstCol = 1;
  function automatic int exp_col(input int step, input int drv);
    return cyc_col[step];
  endfunction
`else
  localparam int RstCol = 0;
  function automatic int exp_col(input int step, input int drv);
    return drv;
  endfunction
`endif

  always @(negedge clk) if (rst_n && (bus.oX > 8'd3 || bus.oY > 7'd2)) bound_viol++;

  // Pulse iDone for one cycle, then wait for the next draw request (lat counted in cycles).
  task automatic pulse_done_wait_load(output int lat, output bit got);
    got = 1'b0;
    bus.iDone = 1'b1;
    @(negedge clk);
    bus.iDone = 1'b0;
    lat = 1;
    while (!got && lat < 40) begin
      if (bus.oLoadX === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    int loads = 0;
    bus.iEnable = 1'b0;
    bus.iDone   = 1'b0;
    bus.iColour = 3'd0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.oLoadX !== 1'b0 || bus.oBusy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: load=%b busy=%b expected 0 0", bus.oLoadX, bus.oBusy);
    end
    checks++;
    if (bus.oX !== 8'd0 || bus.oY !== 7'd0 || int'(bus.oColour) != RstCol) begin
      failures++;
      $display("FAIL reset_pos: x=%0d y=%0d col=%0d expected 0 0 %0d",
               bus.oX, bus.oY, bus.oColour, RstCol);
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.oLoadX === 1'b1) loads++;
    end
    checks++;
    if (loads != 0) begin
      failures++;
      $display("FAIL idle_no_load: loads=%0d expected 0", loads);
    end
  endtask

  task automatic test_first_issue();
    bus.iColour = 3'd5;
    bus.iEnable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.oLoadX !== 1'b1 || bus.oBusy !== 1'b1) begin
      failures++;
      $display("FAIL first_load: load=%b busy=%b expected 1 1", bus.oLoadX, bus.oBusy);
    end
    checks++;
    if (bus.oX !== 8'd0 || bus.oY !== 7'd0 || int'(bus.oColour) != exp_col(0, 5)) begin
      failures++;
      $display("FAIL first_pos: x=%0d y=%0d col=%0d expected 0 0 %0d",
               bus.oX, bus.oY, bus.oColour, exp_col(0, 5));
    end
    @(negedge clk);
    checks++;
    if (bus.oLoadX !== 1'b0 || bus.oBusy !== 1'b1 || bus.oX !== 8'd0 || bus.oY !== 7'd0) begin
      failures++;
      $display("FAIL first_after: load=%b busy=%b x=%0d y=%0d expected 0 1 0 0",
               bus.oLoadX, bus.oBusy, bus.oX, bus.oY);
    end
  endtask

  task automatic test_hold_done();
    int loads = 0, moved = 0, lat;
    bit got;
    repeat (50) begin
      @(negedge clk);
      if (bus.oLoadX === 1'b1) loads++;
      if (bus.oX !== 8'd0 || bus.oY !== 7'd0 || bus.oBusy !== 1'b1) moved++;
    end
    checks++;
    if (loads != 0 || moved != 0) begin
      failures++;
      $display("FAIL hold_done: loads=%0d changes=%0d expected 0 0", loads, moved);
    end
    bus.iColour = 3'd4;
    pulse_done_wait_load(lat, got);
    checks++;
    if (!got || lat < 6 || lat > 9) begin
      failures++;
      $display("FAIL step1_latency: got=%0b lat=%0d expected 1 and 6..9", got, lat);
    end
    checks++;
    if (int'(bus.oX) != 1 || int'(bus.oY) != 1 || int'(bus.oColour) != exp_col(1, 4)) begin
      failures++;
      $display("FAIL step1_pos: x=%0d y=%0d col=%0d expected 1 1 %0d",
               bus.oX, bus.oY, bus.oColour, exp_col(1, 4));
    end
    @(negedge clk);
    checks++;
    if (bus.oLoadX !== 1'b0 || int'(bus.oX) != 1 || int'(bus.oY) != 1) begin
      failures++;
      $display("FAIL step1_hold: load=%b x=%0d y=%0d expected 0 1 1", bus.oLoadX, bus.oX, bus.oY);
    end
  endtask

  task automatic test_bounce();
    int lat, drv;
    bit got;
    for (int k = 2; k < 14; k++) begin
      drv = (k * 3 + 1) % 8;
      bus.iColour = 3'(drv);
      pulse_done_wait_load(lat, got);
      checks++;
      if (!got || lat < 6 || lat > 9) begin
        failures++;
        $display("FAIL step%0d_latency: got=%0b lat=%0d expected 1 and 6..9", k, got, lat);
      end
      checks++;
      if (int'(bus.oX) != exp_x[k] || int'(bus.oY) != exp_y[k] ||
          int'(bus.oColour) != exp_col(k, drv)) begin
        failures++;
        $display("FAIL step%0d_pos: x=%0d y=%0d col=%0d expected %0d %0d %0d", k,
                 bus.oX, bus.oY, bus.oColour, exp_x[k], exp_y[k], exp_col(k, drv));
      end
      @(negedge clk);
      checks++;
      if (bus.oLoadX !== 1'b0 || int'(bus.oX) != exp_x[k] || int'(bus.oY) != exp_y[k]) begin
        failures++;
        $display("FAIL step%0d_hold: load=%b x=%0d y=%0d expected 0 %0d %0d", k,
                 bus.oLoadX, bus.oX, bus.oY, exp_x[k], exp_y[k]);
      end
    end
    checks++;
    if (bound_viol != 0) begin
      failures++;
      $display("FAIL bounds: violations=%0d expected 0", bound_viol);
    end
  endtask

  task automatic test_disable();
    int loads = 0, lat;
    bit got;
    bus.iEnable = 1'b0;
    bus.iDone   = 1'b1;
    @(negedge clk);
    bus.iDone = 1'b0;
    checks++;
    if (bus.oBusy !== 1'b0) begin
      failures++;
      $display("FAIL disable_busy: busy=%b expected 0", bus.oBusy);
    end
    repeat (30) begin
      @(negedge clk);
      if (bus.oLoadX === 1'b1) loads++;
    end
    checks++;
    if (loads != 0 || int'(bus.oX) != 1 || int'(bus.oY) != 1) begin
      failures++;
      $display("FAIL disable_park: loads=%0d x=%0d y=%0d expected 0 1 1", loads, bus.oX, bus.oY);
    end
    bus.iColour = 3'd2;
    bus.iEnable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.oLoadX !== 1'b1 || int'(bus.oX) != 1 || int'(bus.oY) != 1 ||
        int'(bus.oColour) != exp_col(13, 2)) begin
      failures++;
      $display("FAIL resume_load: load=%b x=%0d y=%0d col=%0d expected 1 1 1 %0d",
               bus.oLoadX, bus.oX, bus.oY, bus.oColour, exp_col(13, 2));
    end
    @(negedge clk);
    bus.iColour = 3'd3;
    pulse_done_wait_load(lat, got);
    checks++;
    if (!got || int'(bus.oX) != 2 || int'(bus.oY) != 2) begin
      failures++;
      $display("FAIL resume_step: got=%0b x=%0d y=%0d expected 1 2 2", got, bus.oX, bus.oY);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int loads = 0;
    bus.iEnable = 1'b0;
    bus.iDone   = 1'b1;
    rst_n       = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.oX !== 8'd0 || bus.oY !== 7'd0 || int'(bus.oColour) != RstCol ||
        bus.oLoadX !== 1'b0 || bus.oBusy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_out: x=%0d y=%0d col=%0d load=%b busy=%b expected 0 0 %0d 0 0",
               bus.oX, bus.oY, bus.oColour, bus.oLoadX, bus.oBusy, RstCol);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.iDone = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.oLoadX === 1'b1 || bus.oBusy === 1'b1) loads++;
    end
    checks++;
    if (loads != 0) begin
      failures++;
      $display("FAIL midreset_quiet: active_cycles=%0d expected 0", loads);
    end
    bus.iColour = 3'd6;
    bus.iEnable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.oLoadX !== 1'b1 || bus.oX !== 8'd0 || bus.oY !== 7'd0 ||
        int'(bus.oColour) != exp_col(0, 6)) begin
      failures++;
      $display("FAIL midreset_restart: load=%b x=%0d y=%0d col=%0d expected 1 0 0 %0d",
               bus.oLoadX, bus.oX, bus.oY, bus.oColour, exp_col(0, 6));
    end
  endtask

  initial begin
    test_reset();
    test_first_issue();
    test_hold_done();
    test_bounce();
    test_disable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
